multi_chan_join_fifo: RTL and testbench
=======================================

Name: multi_chan_join_fifo

Overview:
- Generalised successor to the two-channel ctrl/data FIFO pair: NUM_CH independent per-channel sync FIFOs whose heads are joined into one output beat.
- Proper valid/ready on every input channel and on the joined output. The output pops internally, so there is no external shift_out.
- Adds per-channel occupancy, sticky drop flags and synchronous flush.
- Sits between independent producers (e.g. ctrl, data and metadata streams) and a consumer that needs all fields aligned per beat.

Parameters:
- NUM_CH, 2, number of input channels (>=2).
- CH_WIDTH, 32, payload width of each channel (uniform).
- DEPTH, 16, entries per channel FIFO; power of two, >=2.
- CNT_W, $clog2(DEPTH+1), derived (localparam) occupancy counter width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_data  input  NUM_CH*CH_WIDTH  channel payloads; channel i at [i*CH_WIDTH +: CH_WIDTH]
- s_valid  input  NUM_CH  per-channel push request
- s_ready  output  NUM_CH  per-channel space available
- m_data  output  NUM_CH*CH_WIDTH  joined head beat; channel i at the same slice as s_data
- m_valid  output  1  joined beat available
- m_ready  input  1  consumer accepts beat
- flush  input  1  synchronous clear of all FIFO contents
- clr_err  input  1  clears sticky drop flags
- ch_level  output  NUM_CH*CNT_W  per-channel occupancy; channel i at [i*CNT_W +: CNT_W]
- ch_empty  output  NUM_CH  per-channel empty
- all_empty  output  1  every channel (and output stage, if present) empty
- drop  output  NUM_CH  sticky: push attempted while s_ready[i]=0

Behaviour:
- Reset (rst_n low, async): all pointers and levels become 0.
  - Resulting values: s_ready all 1, m_valid=0, m_data=0, ch_empty all 1, all_empty=1, drop=0.
- Each channel is a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap naturally at DEPTH-1 -> 0. The level is held in a separate counter (0..DEPTH).
- Input handshake:
  - s_ready[i] = (level_i != DEPTH). It is registered-state derived and has no combinational path from s_valid or m_ready.
  - Push on s_valid[i] && s_ready[i]. Data is written at the clock edge.
  - Latency: a push into an empty channel is visible at the head on the next cycle.
  - s_valid[i] && !s_ready[i]: the beat is discarded, drop[i] sets the next cycle and stays set until clr_err or reset.
  - No bypass: a full channel does not accept a push even when a pop occurs in the same cycle.
- Output join:
  - m_valid = AND of !ch_empty[i] over all i.
  - m_data is the concatenation of the channel heads (first-word fall-through, combinational read of the head entry).
  - Pop on m_valid && m_ready: every channel's rd_ptr advances by one. A partial pop is impossible.
  - m_valid=0: m_data holds the current head contents; its value is don't-care for the consumer.
- Level arithmetic:
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: level unchanged.
  - The level can never exceed DEPTH or go below 0 by construction.
- flush (sampled at clk):
  - Next cycle all pointers and levels are 0 and m_valid=0.
  - Pushes and the pop in the flush cycle are ignored.
  - drop is not cleared by flush.
- clr_err with a simultaneous new drop event: the set wins and drop[i]=1.
- all_empty = AND of ch_empty, plus the output stage empty when MCJF_OUT_REG_EN is defined.
- Channel skew is allowed: one channel may hold up to DEPTH beats while another holds 0. m_valid waits for the slowest channel.

Optional Feature:
- Macro: MCJF_OUT_REG_EN.
- Defined: a one-entry output register stage is placed after the join.
  - The stage loads the joined heads (popping all channels) when every channel is non-empty and the stage is empty or being consumed this cycle (m_ready=1).
  - m_data/m_valid are driven from registers, so no combinational path exists from the FIFO RAM to the output.
  - Push-to-m_valid latency is 2 cycles; throughput stays 1 beat/cycle.
  - flush also invalidates the stage.
  - Reset clears the stage to m_valid=0, m_data=0.
- Undefined: the combinational FWFT join described above, with 1-cycle latency.

Test Plan:
- Reset, NUM_CH=2: push 0xA1 on ch0 and 0xB1 on ch1 in the same cycle, m_ready=1 -> next cycle m_valid=1, m_data={0xB1,0xA1}; the cycle after, m_valid=0 and all_empty=1.
- Skew: push 3 beats on ch0 (0x10,0x11,0x12), none on ch1 -> m_valid stays 0 and ch_level0=3. Then push 0x20 on ch1 -> m_valid=1, m_data={0x20,0x10}; after the pop ch_level0=2.
- Full/drop, DEPTH=4, m_ready=0: push 5 beats on ch0 -> s_ready[0]=0 after the 4th, the 5th beat is lost, drop[0]=1 and ch_level0=4. clr_err -> drop[0]=0.
- Full with simultaneous pop: ch0 and ch1 at level 4, m_ready=1, s_valid=2'b11 -> pushes are refused that cycle and levels drop to 3. Next cycle, push and pop together keep the levels at 3.
- Wrap-around, DEPTH=4: stream 10 beats per channel with m_ready=1 -> the output sequence matches the input order exactly and drop=0.
- flush mid-stream with levels {2,3} -> next cycle levels 0, m_valid=0, drop unchanged. With MCJF_OUT_REG_EN defined, latency is 2 cycles and a full stage is cleared.

Source files
------------

// File: rtl/multi_chan_join_fifo.sv
// rtl/multi_chan_join_fifo.sv - NUM_CH per-channel sync FIFOs joined into one output beat (optional output stage: MCJF_OUT_REG_EN)
module multi_chan_join_fifo #(
  parameter int NUM_CH   = 2,
  parameter int CH_WIDTH = 32,
  parameter int DEPTH    = 16,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*CH_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]          s_valid,
  output logic [NUM_CH-1:0]          s_ready,
  output logic [NUM_CH*CH_WIDTH-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [NUM_CH*CNT_W-1:0]    ch_level,
  output logic [NUM_CH-1:0]          ch_empty,
  output logic                       all_empty,
  output logic [NUM_CH-1:0]          drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CH_WIDTH-1:0]        mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]           wr_ptr [NUM_CH];
  logic [PTR_W-1:0]           rd_ptr [NUM_CH];
  logic [CNT_W-1:0]           level  [NUM_CH];
  logic [NUM_CH-1:0]          push;
  logic [NUM_CH-1:0]          not_empty;
  logic [NUM_CH*CH_WIDTH-1:0] heads;
  logic                       all_ne;
  logic                       pop;

  // Per-channel status and head-entry read; s_ready depends only on registered levels
  always_comb begin
    s_ready   = '0;
    not_empty = '0;
    push      = '0;
    heads     = '0;
    ch_level  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_ready[i]                       = (level[i] != CNT_W'(DEPTH));
      not_empty[i]                     = (level[i] != '0);
      push[i]                          = s_valid[i] && s_ready[i];
      heads[i*CH_WIDTH +: CH_WIDTH]    = mem[i][rd_ptr[i]];
      ch_level[i*CNT_W +: CNT_W]       = level[i];
    end
    ch_empty = ~not_empty;
    all_ne   = &not_empty;
  end

`ifdef MCJF_OUT_REG_EN
  logic                       out_valid;
  logic [NUM_CH*CH_WIDTH-1:0] out_data;

  // Output stage refills whenever it is empty or its beat is being taken
  always_comb begin
    pop       = all_ne && (!out_valid || m_ready);
    m_valid   = out_valid;
    m_data    = out_data;
    all_empty = ~|not_empty && !out_valid;
  end

  // One-entry output register after the join
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= heads;
    end else if (m_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  // Combinational first-word fall-through join
  always_comb begin
    pop       = all_ne && m_ready;
    m_valid   = all_ne;
    m_data    = heads;
    all_empty = ~|not_empty;
  end
`endif

  // Channel storage, pointers and levels; flush discards the cycle's pushes and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        level[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        level[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= s_data[i*CH_WIDTH +: CH_WIDTH];
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        case ({push[i], pop})
          2'b10:   level[i] <= level[i] + 1'b1;
          2'b01:   level[i] <= level[i] - 1'b1;
          default: level[i] <= level[i];
        endcase
      end
    end
  end

  // Sticky drop flags; a new refused push outranks clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= '0;
    end else begin
      drop <= (drop & ~{NUM_CH{clr_err}}) | (s_valid & ~s_ready);
    end
  end

endmodule

// File: tb/tb_multi_chan_join_fifo.sv
// tb/tb_multi_chan_join_fifo.sv - randomized and directed checks of multi_chan_join_fifo against a queue model
module tb_multi_chan_join_fifo;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH*CH_W-1:0]   s_data = '0;
  logic [NUM_CH-1:0]        s_valid = '0;
  logic [NUM_CH-1:0]        s_ready;
  logic [NUM_CH*CH_W-1:0]   m_data;
  logic                     m_valid;
  logic                     m_ready = 1'b0;
  logic                     flush = 1'b0;
  logic                     clr_err = 1'b0;
  logic [NUM_CH*CNT_W-1:0]  ch_level;
  logic [NUM_CH-1:0]        ch_empty;
  logic                     all_empty;
  logic [NUM_CH-1:0]        drop;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  logic [CH_W-1:0]   q [NUM_CH][$];
  logic [NUM_CH-1:0] md_drop = '0;

  multi_chan_join_fifo #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .flush(flush), .clr_err(clr_err),
    .ch_level(ch_level), .ch_empty(ch_empty), .all_empty(all_empty), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] lvl(input int ch);
    return ch_level[ch*CNT_W +: CNT_W];
  endfunction

  // Reference model: one queue per channel, updated from the inputs seen at each edge
  always @(posedge clk) begin
    logic [NUM_CH-1:0] rdy;
    bit                pop;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) q[i].delete();
      md_drop = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) rdy[i] = (q[i].size() != DEPTH);
      md_drop = (md_drop & ~{NUM_CH{clr_err}}) | (s_valid & ~rdy);
      if (flush) begin
        for (int i = 0; i < NUM_CH; i++) q[i].delete();
      end else begin
        pop = m_ready;
        for (int i = 0; i < NUM_CH; i++) if (q[i].size() == 0) pop = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (pop) void'(q[i].pop_front());
          if (s_valid[i] && rdy[i]) q[i].push_back(s_data[i*CH_W +: CH_W]);
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    logic [NUM_CH-1:0]      e_rdy, e_emp;
    logic [NUM_CH*CH_W-1:0] e_data;
    bit                     e_mv;
    if (rst_n && chk_en) begin
      e_mv = 1'b1;
      e_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        e_rdy[i] = (q[i].size() != DEPTH);
        e_emp[i] = (q[i].size() == 0);
        if (e_emp[i]) e_mv = 1'b0;
        else e_data[i*CH_W +: CH_W] = q[i][0];
        chk($sformatf("ch_level%0d", i), 32'(lvl(i)), 32'(q[i].size()));
      end
      chk("s_ready", 32'(s_ready), 32'(e_rdy));
      chk("ch_empty", 32'(ch_empty), 32'(e_emp));
      chk("all_empty", 32'(all_empty), 32'(&e_emp));
      chk("m_valid", 32'(m_valid), 32'(e_mv));
      chk("drop", 32'(drop), 32'(md_drop));
      if (e_mv) chk("m_data", 32'(m_data), 32'(e_data));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_s_ready", 32'(s_ready), 32'h3);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_ch_empty", 32'(ch_empty), 32'h3);
    chk("rst_all_empty", 32'(all_empty), 32'h1);
    chk("rst_drop", 32'(drop), 32'h0);

    // Simultaneous push on both channels, consumer ready
    s_data = 16'hB1A1; s_valid = 2'b11; m_ready = 1'b1;
    cyc(); s_valid = 2'b00;
    chk("t1_m_valid", 32'(m_valid), 32'h1);
    chk("t1_m_data", 32'(m_data), 32'hB1A1);
    cyc();
    chk("t1_m_valid_after", 32'(m_valid), 32'h0);
    chk("t1_all_empty", 32'(all_empty), 32'h1);

    // Skew: ch0 ahead of ch1
    for (int k = 0; k < 3; k++) begin
      s_data = {8'h00, 8'(8'h10 + k)}; s_valid = 2'b01; cyc();
    end
    s_valid = 2'b00;
    chk("t2_m_valid", 32'(m_valid), 32'h0);
    chk("t2_level0", 32'(lvl(0)), 32'h3);
    s_data = 16'h2000; s_valid = 2'b10; cyc(); s_valid = 2'b00;
    chk("t2_join_valid", 32'(m_valid), 32'h1);
    chk("t2_join_data", 32'(m_data), 32'h2010);
    cyc();
    chk("t2_level0_pop", 32'(lvl(0)), 32'h2);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("t2_flush_level0", 32'(lvl(0)), 32'h0);

    // Overfill ch0 with the consumer stalled
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_data = {8'h00, 8'(8'h50 + k)}; s_valid = 2'b01; cyc();
      if (k == 3) chk("t3_s_ready0_full", 32'(s_ready[0]), 32'h0);
    end
    s_valid = 2'b00;
    chk("t3_drop0", 32'(drop[0]), 32'h1);
    chk("t3_level0", 32'(lvl(0)), 32'h4);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("t3_drop_clr", 32'(drop), 32'h0);
    flush = 1'b1; cyc(); flush = 1'b0;

    // Both full, pop with refused pushes, then push+pop steady state
    for (int k = 0; k < 4; k++) begin
      s_data = {8'(8'h60 + k), 8'(8'h70 + k)}; s_valid = 2'b11; cyc();
    end
    m_ready = 1'b1; s_data = 16'hEEEE; cyc();
    chk("t4_level0_refused", 32'(lvl(0)), 32'h3);
    chk("t4_level1_refused", 32'(lvl(1)), 32'h3);
    chk("t4_m_data", 32'(m_data), 32'h6171);
    s_data = 16'hDDCC; cyc();
    chk("t4_level0_steady", 32'(lvl(0)), 32'h3);
    chk("t4_level1_steady", 32'(lvl(1)), 32'h3);
    s_valid = 2'b00;

    // Flush with uneven levels; drop flags from the refused pushes must survive
    flush = 1'b1; cyc(); flush = 1'b0;
    m_ready = 1'b0;
    s_valid = 2'b11; cyc(); cyc();
    s_valid = 2'b10; cyc();
    chk("t6_level0_pre", 32'(lvl(0)), 32'h2);
    chk("t6_level1_pre", 32'(lvl(1)), 32'h3);
    flush = 1'b1; s_valid = 2'b11; m_ready = 1'b1; cyc();
    flush = 1'b0; s_valid = 2'b00;
    chk("t6_level0", 32'(lvl(0)), 32'h0);
    chk("t6_level1", 32'(lvl(1)), 32'h0);
    chk("t6_m_valid", 32'(m_valid), 32'h0);
    chk("t6_drop_kept", 32'(drop), 32'h3);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("t6_drop_clr", 32'(drop), 32'h0);

    // Streaming across pointer wrap
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = {8'(8'h40 + k), 8'(8'h30 + k)}; s_valid = 2'b11; cyc();
      chk($sformatf("t5_m_valid_%0d", k), 32'(m_valid), 32'h1);
      chk($sformatf("t5_m_data_%0d", k), 32'(m_data), 32'({8'(8'h40 + k), 8'(8'h30 + k)}));
    end
    s_valid = 2'b00; cyc();
    chk("t5_all_empty", 32'(all_empty), 32'h1);
    chk("t5_drop", 32'(drop), 32'h0);

    // Randomized traffic with varying consumer throttle
    for (int e = 0; e < 15; e++) begin
      int thr;
      thr = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        s_data  = NUM_CH*CH_W'($urandom);
        s_valid = NUM_CH'($urandom);
        m_ready = ($urandom_range(0, 99) < thr);
        flush   = ($urandom_range(0, 63) == 0);
        clr_err = ($urandom_range(0, 31) == 0);
        cyc();
      end
    end
    s_valid = '0; flush = 1'b0; clr_err = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
